// File: rtl/frame_pkg.sv
// Shared types, defaults and arithmetic helpers for the multi-channel frame parser.
package frame_pkg;

    localparam int unsigned LEN_W = 7;
    localparam logic [31:0] HEADER_DEF  = 32'hE0E0E0E0;
    localparam logic [31:0] TRAILER_DEF = 32'h0E0E0E0E;

    typedef enum logic [2:0] {HUNT, HDR2, CHAN, DATA, TRL2} state_e;

    typedef struct packed {
        logic crc_valid;
        logic crc_err;
        logic err_chan;
        logic err_len;
        logic err_trailer;
        logic err_overrun;
    } status_t;

    // CRC-16/XMODEM over one 16-bit word, MSB first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] gray_word(input logic [15:0] w, input logic p);
        return w ^ {p, w[15:1]};
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: simple dual-port, one write and one registered read per cycle.
module frame_bank_ram
    import frame_pkg::*;
#(
    parameter int unsigned DEPTH = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic             wr_bank_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [15:0]      wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_bank_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [15:0]      rd_data_o
);

    logic [15:0] mem_q [2][DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en_i) mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
    end

    // Read register doubles as the output data register, so it holds during stalls
    always_ff @(posedge clk_in) begin
        if (rst)          rd_data_o <= '0;
        else if (rd_en_i) rd_data_o <= mem_q[rd_bank_i][rd_idx_i];
    end

endmodule

// File: rtl/frame_parser_mc.sv
// Framed 16-bit stream parser: CRC-checked payloads buffered in a ping-pong store and
// released in commit order on a valid/ready port, optionally Gray coded.
module frame_parser_mc
    import frame_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned MAX_WORDS = 8,
    parameter bit          GRAY_EN   = 1'b1,
    parameter logic [31:0] HEADER    = HEADER_DEF,
    parameter logic [31:0] TRAILER   = TRAILER_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [15:0]      data_in,
    input  logic             in_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [N_CH-1:0]  out_ch,
    output logic [LEN_W-1:0] out_len,
    output logic             out_last,
    output logic             crc_valid,
    output logic             crc_err,
    output logic             err_chan,
    output logic             err_len,
    output logic             err_trailer,
    output logic             err_overrun
);

    localparam int unsigned DEPTH = MAX_WORDS + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [15:0] CH_MASK = 16'((32'd1 << N_CH) - 32'd1);

    state_e                      state_q, state_d;
    logic [LEN_W-1:0]            cnt_q, cnt_d;
    logic [15:0]                 crc_acc_q, crc_acc_d, hold_q, hold_d;
    logic                        wr_bank_q, wr_bank_d;
    logic [1:0]                  busy_q, busy_d;
    logic [1:0][N_CH-1:0]        ch_q, ch_d;
    logic [1:0][LEN_W-1:0]       len_q, len_d;
    logic [1:0]                  fifo_q, fifo_d;
    logic [1:0]                  fifo_cnt_q, fifo_cnt_d;
    logic [IDX_W-1:0]            rd_idx_q, rd_idx_d;
    logic                        out_valid_q, out_valid_d, out_last_q, out_bank_q, p_q;
    logic [N_CH-1:0]             out_ch_q;
    logic [LEN_W-1:0]            out_len_q;
    status_t                     stat_q, stat_d;
    logic                        alloc, discard, commit, wr_en, chan_ok;
    logic                        head, rd_en, rd_last, pop, free;
    logic [15:0]                 rd_data;

    assign chan_ok = $onehot(data_in) && ((data_in & ~CH_MASK) == 16'h0000);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_acc_d = crc_acc_q;
        hold_d    = hold_q;
        wr_bank_d = wr_bank_q;
        ch_d      = ch_q;
        len_d     = len_q;
        stat_d    = '0;
        alloc     = 1'b0;
        discard   = 1'b0;
        commit    = 1'b0;
        wr_en     = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: if (data_in == HEADER[31:16]) state_d = HDR2;
                HDR2: begin
                    if (data_in == HEADER[15:0]) begin
                        if (busy_q == 2'b11) begin
                            stat_d.err_overrun = 1'b1;
                            state_d            = HUNT;
                        end else begin
                            alloc     = 1'b1;
                            wr_bank_d = busy_q[0];
                            state_d   = CHAN;
                        end
                    end else if (data_in != HEADER[31:16]) begin
                        state_d = HUNT;
                    end
                end
                CHAN: begin
                    if (chan_ok) begin
                        ch_d[wr_bank_q] = data_in[N_CH-1:0];
                        cnt_d           = '0;
                        crc_acc_d       = '0;
                        state_d         = DATA;
                    end else begin
                        stat_d.err_chan = 1'b1;
                        discard         = 1'b1;
                        state_d         = HUNT;
                    end
                end
                DATA: begin
                    if (data_in == TRAILER[31:16]) begin
                        state_d = TRL2;
                    end else if (cnt_q == DEPTH_L) begin
                        stat_d.err_len = 1'b1;
                        discard        = 1'b1;
                        state_d        = HUNT;
                    end else begin
                        // Newest word waits in hold_q; it only enters the CRC once superseded
                        wr_en  = 1'b1;
                        cnt_d  = cnt_q + LEN_W'(1);
                        hold_d = data_in;
                        if (cnt_q != '0) crc_acc_d = crc16_step(crc_acc_q, hold_q);
                    end
                end
                TRL2: begin
                    state_d = HUNT;
                    if (data_in != TRAILER[15:0]) begin
                        stat_d.err_trailer = 1'b1;
                        discard            = 1'b1;
                    end else if (cnt_q < LEN_W'(2)) begin
                        stat_d.err_len = 1'b1;
                        discard        = 1'b1;
                    end else if (crc_acc_q == hold_q) begin
                        stat_d.crc_valid = 1'b1;
                        commit           = 1'b1;
                        len_d[wr_bank_q] = cnt_q - LEN_W'(1);
                    end else begin
                        stat_d.crc_err = 1'b1;
                        discard        = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Read side: head of the commit queue streams into the RAM output register
    always_comb begin
        head        = fifo_q[0];
        rd_en       = (fifo_cnt_q != 2'd0) && (!out_valid_q || out_ready);
        rd_last     = (LEN_W'(rd_idx_q) == len_q[head] - LEN_W'(1));
        pop         = rd_en && rd_last;
        free        = out_valid_q && out_ready && out_last_q;
        out_valid_d = rd_en ? 1'b1 : (out_valid_q && !out_ready);
        rd_idx_d    = rd_idx_q;
        if (rd_en) rd_idx_d = rd_last ? '0 : rd_idx_q + IDX_W'(1);

        fifo_d     = fifo_q;
        fifo_cnt_d = fifo_cnt_q;
        if (pop) begin
            fifo_d[0]  = fifo_q[1];
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        if (commit) begin
            fifo_d[fifo_cnt_d[0]] = wr_bank_q;
            fifo_cnt_d            = fifo_cnt_d + 2'd1;
        end

        busy_d = busy_q;
        if (free)    busy_d[out_bank_q] = 1'b0;
        if (discard) busy_d[wr_bank_q]  = 1'b0;
        if (alloc)   busy_d[wr_bank_d]  = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            crc_acc_q   <= '0;
            hold_q      <= '0;
            wr_bank_q   <= 1'b0;
            busy_q      <= '0;
            ch_q        <= '0;
            len_q       <= '0;
            fifo_q      <= '0;
            fifo_cnt_q  <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bank_q  <= 1'b0;
            out_ch_q    <= '0;
            out_len_q   <= '0;
            p_q         <= 1'b0;
            stat_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_acc_q   <= crc_acc_d;
            hold_q      <= hold_d;
            wr_bank_q   <= wr_bank_d;
            busy_q      <= busy_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            fifo_q      <= fifo_d;
            fifo_cnt_q  <= fifo_cnt_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            stat_q      <= stat_d;
            if (rd_en) begin
                out_last_q <= rd_last;
                out_bank_q <= head;
                out_ch_q   <= ch_q[head];
                out_len_q  <= len_q[head];
                // rd_data still holds the previous word of this frame
                p_q        <= (rd_idx_q == '0) ? 1'b0 : rd_data[0];
            end
        end
    end

    frame_bank_ram #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_ram (
        .clk_in   (clk_in),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_bank_i(wr_bank_q),
        .wr_idx_i (cnt_q[IDX_W-1:0]),
        .wr_data_i(data_in),
        .rd_en_i  (rd_en),
        .rd_bank_i(head),
        .rd_idx_i (rd_idx_q),
        .rd_data_o(rd_data)
    );

    assign out_valid   = out_valid_q;
    assign out_data    = GRAY_EN ? gray_word(rd_data, p_q) : rd_data;
    assign out_ch      = out_ch_q;
    assign out_len     = out_len_q;
    assign out_last    = out_last_q;
    assign crc_valid   = stat_q.crc_valid;
    assign crc_err     = stat_q.crc_err;
    assign err_chan    = stat_q.err_chan;
    assign err_len     = stat_q.err_len;
    assign err_trailer = stat_q.err_trailer;
    assign err_overrun = stat_q.err_overrun;

endmodule

// File: tb/tb_frame_parser_mc.sv
// Directed bench for frame_parser_mc with default parameters (8 channels, 8 words, Gray on).
module tb_frame_parser_mc;

    logic        clk_in = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [15:0] data_in;
    logic        out_valid, out_last;
    logic [15:0] out_data;
    logic [7:0]  out_ch;
    logic [6:0]  out_len;
    logic        crc_valid, crc_err, err_chan, err_len, err_trailer, err_overrun;
    logic [5:0]  stat;

    localparam logic [5:0] S_OK   = 6'b100000;
    localparam logic [5:0] S_CRC  = 6'b010000;
    localparam logic [5:0] S_CHAN = 6'b001000;
    localparam logic [5:0] S_LEN  = 6'b000100;
    localparam logic [5:0] S_TRL  = 6'b000010;
    localparam logic [5:0] S_OVR  = 6'b000001;

    int          errors = 0;
    int          checks = 0;
    logic [5:0]  seen;
    int          pulse_cycles;
    bit          valid_seen;
    logic [15:0] pay[$];
    logic [15:0] fr_pay[$];
    int          fr_len[$];
    logic [7:0]  fr_ch[$];
    logic [15:0] first_w[2];

    assign stat = {crc_valid, crc_err, err_chan, err_len, err_trailer, err_overrun};

    always #5 clk_in = ~clk_in;

    frame_parser_mc dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_len    (out_len),
        .out_last   (out_last),
        .crc_valid  (crc_valid),
        .crc_err    (crc_err),
        .err_chan   (err_chan),
        .err_len    (err_len),
        .err_trailer(err_trailer),
        .err_overrun(err_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (stat != 6'b0) begin
            seen |= stat;
            pulse_cycles++;
        end
        if (out_valid) valid_seen = 1'b1;
    endtask

    // Byte-serial XMODEM CRC over the payload queue
    function automatic logic [15:0] crc_bytes();
        logic [15:0] c;
        c = 16'h0000;
        foreach (pay[i]) begin
            for (int b = 1; b >= 0; b--) begin
                c = c ^ {pay[i][8*b +: 8], 8'h00};
                for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic send_word(input logic [15:0] w);
        data_in  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = 16'h0000;
    endtask

    task automatic send_frame(input logic [15:0] ch, input logic [15:0] trl_lo,
                              input bit bad_crc, input logic [15:0] bad_val);
        logic [15:0] crc;
        crc          = bad_crc ? bad_val : crc_bytes();
        seen         = 6'b0;
        pulse_cycles = 0;
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        send_word(ch);
        foreach (pay[i]) send_word(pay[i]);
        send_word(crc);
        send_word(16'h0E0E);
        send_word(trl_lo);
    endtask

    task automatic check_status(input string tag, input logic [5:0] exp);
        tick();
        chk({tag, ":status"}, 32'(seen), 32'(exp));
        chk({tag, ":pulses"}, pulse_cycles, 1);
    endtask

    task automatic push_model(input logic [7:0] ch);
        foreach (pay[i]) fr_pay.push_back(pay[i]);
        fr_len.push_back(pay.size());
        fr_ch.push_back(ch);
    endtask

    task automatic drain_frame(input string tag, input bit rnd);
        int          n, idx, cyc;
        logic [7:0]  ch;
        logic [15:0] ew[$];
        logic        p;
        logic [31:0] snap;
        bit          stalled;
        n = fr_len.pop_front();
        ch = fr_ch.pop_front();
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = fr_pay.pop_front();
            ew.push_back(w ^ {p, w[15:1]});
            p = w[0];
        end
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        while (idx < n && cyc < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                chk({tag, ":data"}, out_data, ew[idx]);
                chk({tag, ":ch"}, out_ch, ch);
                chk({tag, ":len"}, out_len, n);
                chk({tag, ":last"}, out_last, (idx == n - 1));
                if (idx < 2) first_w[idx] = out_data;
                idx++;
            end else if (out_valid) begin
                snap = {out_data, out_ch, out_len, out_last};
                stalled = 1'b1;
            end
            tick();
            cyc++;
            if (stalled) begin
                chk({tag, ":stall"}, {out_valid, out_data, out_ch, out_len},
                    {1'b1, snap[31:1]});
                chk({tag, ":stall_last"}, out_last, snap[0]);
                stalled = 1'b0;
            end
        end
        out_ready = 1'b0;
        chk({tag, ":words"}, idx, n);
    endtask

    task automatic idle_watch(input string tag);
        valid_seen = 1'b0;
        out_ready  = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        chk({tag, ":no_output"}, valid_seen, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        data_in = 16'h0000;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset:out", {out_valid, out_data, out_ch, out_len, out_last}, 0);
        chk("reset:status", stat, 0);

        // Single-word frame, fixed Gray value
        pay = {16'hA55A};
        send_frame(16'h0001, 16'h0E0E, 1'b0, 16'h0);
        check_status("t1", S_OK);
        chk("t1:valid", out_valid, 1);
        chk("t1:data", out_data, 16'hF7F7);
        chk("t1:ch", out_ch, 8'h01);
        chk("t1:len", out_len, 1);
        chk("t1:last", out_last, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1:drained", out_valid, 0);

        // Full-length frame under random backpressure
        pay = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
        send_frame(16'h0002, 16'h0E0E, 1'b0, 16'h0);
        check_status("t2", S_OK);
        push_model(8'h02);
        drain_frame("t2", 1'b1);
        chk("t2:w0", first_w[0], 16'h01B2);
        chk("t2:w1", first_w[1], 16'hE7D4);

        // Bad CRC
        pay = {16'h1234};
        send_frame(16'h0001, 16'h0E0E, 1'b1, 16'hFFFF);
        check_status("t3", S_CRC);
        idle_watch("t3");

        // Bad channel, then a good frame
        pay = {16'h5A5A};
        send_frame(16'h0003, 16'h0E0E, 1'b0, 16'h0);
        check_status("t4", S_CHAN);
        idle_watch("t4");
        pay = {16'h1111, 16'h2222};
        send_frame(16'h0004, 16'h0E0E, 1'b0, 16'h0);
        check_status("t4b", S_OK);
        push_model(8'h04);
        drain_frame("t4b", 1'b0);

        // Both banks held by committed frames: third header overruns
        pay = {16'hAAAA, 16'h5555, 16'h0F0F};
        send_frame(16'h0008, 16'h0E0E, 1'b0, 16'h0);
        check_status("t5a", S_OK);
        push_model(8'h08);
        pay = {16'hBEEF};
        send_frame(16'h0010, 16'h0E0E, 1'b0, 16'h0);
        check_status("t5b", S_OK);
        push_model(8'h10);
        pay = {16'hCAFE};
        send_frame(16'h0020, 16'h0E0E, 1'b0, 16'h0);
        check_status("t5c", S_OVR);
        drain_frame("t5a", 1'b0);
        drain_frame("t5b", 1'b0);

        // Too many words, then a good frame
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(16'(16'h0101 + i * 16'h1111));
        send_frame(16'h0040, 16'h0E0E, 1'b0, 16'h0);
        check_status("t6", S_LEN);
        pay = {16'h0F00, 16'h00F0, 16'h000F};
        send_frame(16'h0040, 16'h0E0E, 1'b0, 16'h0);
        check_status("t6b", S_OK);
        push_model(8'h40);
        drain_frame("t6b", 1'b1);

        // CRC only, no payload
        pay = {};
        send_frame(16'h0001, 16'h0E0E, 1'b0, 16'h0);
        check_status("t6c", S_LEN);

        // Wrong trailer low half, then a good frame
        pay = {16'h7777};
        send_frame(16'h0080, 16'h0E0F, 1'b0, 16'h0);
        check_status("t7", S_TRL);
        pay = {16'h8001, 16'h4003};
        send_frame(16'h0080, 16'h0E0E, 1'b0, 16'h0);
        check_status("t7b", S_OK);
        push_model(8'h80);
        drain_frame("t7b", 1'b1);

        // Reset mid-DATA with a committed frame waiting at the output
        pay = {16'h1357};
        send_frame(16'h0002, 16'h0E0E, 1'b0, 16'h0);
        check_status("t8a", S_OK);
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        send_word(16'h0001);
        send_word(16'h2468);
        send_word(16'h1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t8:out", {out_valid, out_data, out_ch, out_len, out_last}, 0);
        chk("t8:status", stat, 0);
        idle_watch("t8");
        pay = {16'h9ABC, 16'hDEF0};
        send_frame(16'h0001, 16'h0E0E, 1'b0, 16'h0);
        check_status("t8b", S_OK);
        push_model(8'h01);
        drain_frame("t8b", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
